// File: rtl/inst_prefetch_pkg.sv
// rtl/inst_prefetch_pkg.sv - shared types and constants for the instruction prefetch front end
// Entry layout, default sizing and the fetch state encoding.
package inst_prefetch_pkg;
   localparam int          DEFAULT_DEPTH    = 4;
   localparam int          PTR_W            = $clog2(DEFAULT_DEPTH);
   localparam int          CNT_W            = PTR_W + 1;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] WORD_INC         = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   typedef enum logic {
      ST_RUN,
      ST_DRAIN
   } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous queue of fetched {pc, word} entries
// Head is read straight from storage; clear empties the queue in one cycle.
module fetch_fifo
   import inst_prefetch_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic [31:0]                push_pc,
   input  logic [31:0]                push_word,
   input  logic                       pop,
   output logic [31:0]                head_pc,
   output logic [31:0]                head_word,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int                QPTR_W  = $clog2(DEPTH);
   localparam int                QCNT_W  = QPTR_W + 1;
   localparam logic [QPTR_W-1:0] PTR_ONE = QPTR_W'(1);
   localparam logic [QCNT_W-1:0] CNT_ONE = QCNT_W'(1);
   localparam logic [QCNT_W-1:0] CNT_MAX = QCNT_W'(DEPTH);

   fetch_entry_t      mem_q [DEPTH];
   logic [QPTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [QCNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{pc: push_pc, word: push_word};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_q <= count_q + CNT_ONE;
         else if (pop && !push) count_q <= count_q - CNT_ONE;
      end
   end

   // The credit scheme upstream makes these unreachable; they guard the invariant.
   always_ff @(posedge clk) begin
      if (!rst && !clear) begin
         if (push && !pop) assert (count_q != CNT_MAX);
         if (pop)          assert (count_q != '0);
      end
   end

   assign head_pc   = mem_q[rd_ptr_q].pc;
   assign head_word = mem_q[rd_ptr_q].word;
   assign count     = count_q;
endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - sequential instruction prefetcher with redirect flush and stale-response drain
// Optional FETCH_BYPASS_EN forwards a response straight to the datapath when the queue is empty.
module inst_prefetch
   import inst_prefetch_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);
   localparam int            CW         = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

   fetch_state_e  state_q;
   logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d, count;
   logic [31:0]   head_pc, head_word;
   logic          q_empty, req_fire, rsp_take, bypass, push, pop;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect),
      .push      (push),
      .push_pc   (rsp_pc_q),
      .push_word (mem_rsp_data),
      .pop       (pop),
      .head_pc   (head_pc),
      .head_word (head_word),
      .count     (count)
   );

   // Every issued request owns a queue slot until its word is popped or dropped.
   assign q_empty       = (count == '0);
   assign mem_req_valid = !rst && !redirect && (({1'b0, count} + {1'b0, outstanding_q}) < CREDIT_MAX);
   assign mem_req_addr  = fetch_pc_q;
   assign req_fire      = mem_req_valid && mem_req_ready;
   assign rsp_take      = mem_rsp_valid && !redirect && (state_q == ST_RUN);

`ifdef FETCH_BYPASS_EN
   assign bypass = rsp_take && q_empty;
`else
   assign bypass = 1'b0;
`endif

   assign inst_valid = !q_empty || bypass;
   assign pop        = !q_empty && inst_ready && !redirect;
   assign push       = rsp_take && !(bypass && inst_ready);

   always_comb begin
      inst    = 32'h0;
      inst_pc = 32'h0;
      if (!q_empty) begin
         inst    = head_word;
         inst_pc = head_pc;
      end else if (bypass) begin
         inst    = mem_rsp_data;
         inst_pc = rsp_pc_q;
      end
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      if (req_fire && !mem_rsp_valid)      outstanding_d = outstanding_q + CNT_ONE;
      else if (!req_fire && mem_rsp_valid) outstanding_d = outstanding_q - CNT_ONE;
      if (redirect) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         rsp_pc_d   = redirect_pc & ~32'h3;
         // Everything still in flight is stale, except a response landing right now.
         drop_d     = mem_rsp_valid ? (outstanding_q - CNT_ONE) : outstanding_q;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + WORD_INC;
         if (rsp_take) rsp_pc_d   = rsp_pc_q + WORD_INC;
         if (mem_rsp_valid && (state_q == ST_DRAIN)) drop_d = drop_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         state_q       <= (drop_d != '0) ? ST_DRAIN : ST_RUN;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end
endmodule

// File: tb/tb_inst_prefetch.sv
// tb/tb_inst_prefetch.sv - randomized bench for inst_prefetch against a transaction-level model
// Memory is a queue of pending requests tagged stale on redirect; delivered words form the expected queue.
module tb_inst_prefetch;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, redirect, mem_req_valid, mem_req_ready, mem_rsp_valid, inst_valid, inst_ready;
   logic [31:0] redirect_pc, mem_req_addr, mem_rsp_data, inst, inst_pc;

   inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .inst_pc       (inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] qpc[$];
   logic [31:0] qword[$];
   logic [31:0] exp_fetch;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] pick_pc();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0100;
         1:       return 32'h0000_0203;
         2:       return 32'h0000_0400;
         3:       return 32'hFFFF_FFF4;
         4:       return 32'hFFFF_FFFB;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
      @(negedge clk);
      #1;
      check_eq("rst_req_valid",  {31'b0, mem_req_valid}, 32'h0);
      check_eq("rst_inst_valid", {31'b0, inst_valid},    32'h0);
      check_eq("rst_inst",       inst,                   32'h0);
      check_eq("rst_inst_pc",    inst_pc,                32'h0);
      pend.delete(); qpc.delete(); qword.delete();
      exp_fetch = 32'h0;
   endtask

   task automatic run_cycles(input int n, input int p_redir, input int p_mready,
                             input int p_iready, input int lat_max, input int p_rsp);
      bit          byp, exp_iv, exp_rv;
      pend_t       p;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst           = 1'b0;
         redirect      = ($urandom_range(0, 99) < p_redir);
         redirect_pc   = pick_pc();
         mem_req_ready = ($urandom_range(0, 99) < p_mready);
         inst_ready    = ($urandom_range(0, 99) < p_iready);
         if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < p_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word_of(pend[0].addr);
         end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
         end
         #1;
         byp = 1'b0;
`ifdef FETCH_BYPASS_EN
         if (!redirect && mem_rsp_valid && qpc.size() == 0 && !pend[0].stale) byp = 1'b1;
`endif
         exp_iv = (qpc.size() > 0) || byp;
         exp_rv = !redirect && (qpc.size() + pend.size() < DEPTH);
         check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
         if (qpc.size() > 0) begin
            check_eq("inst_pc", inst_pc, qpc[0]);
            check_eq("inst",    inst,    qword[0]);
         end else if (byp) begin
            check_eq("byp_inst_pc", inst_pc, pend[0].addr);
            check_eq("byp_inst",    inst,    word_of(pend[0].addr));
         end
         check_eq("req_valid", {31'b0, mem_req_valid}, {31'b0, exp_rv});
         if (exp_rv) check_eq("req_addr", mem_req_addr, exp_fetch);

         if (redirect) begin
            if (mem_rsp_valid) void'(pend.pop_front());
            foreach (pend[k]) pend[k].stale = 1'b1;
            qpc.delete(); qword.delete();
            exp_fetch = redirect_pc & ~32'h3;
         end else begin
            if (inst_ready && qpc.size() > 0) begin
               void'(qpc.pop_front());
               void'(qword.pop_front());
            end
            if (mem_rsp_valid) begin
               p = pend.pop_front();
               if (!p.stale && !(byp && inst_ready)) begin
                  qpc.push_back(p.addr);
                  qword.push_back(word_of(p.addr));
               end
            end
            if (exp_rv && mem_req_ready) begin
               pend.push_back('{addr: exp_fetch, stale: 1'b0,
                                due: cyc + 1 + int'($urandom_range(0, lat_max))});
               exp_fetch = exp_fetch + 32'd4;
            end
         end
         cyc++;
      end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
      do_reset();
      run_cycles(40,  0, 100, 100, 0, 100);
      run_cycles(20,  0, 100,   0, 0, 100);
      run_cycles(20,  0, 100, 100, 0, 100);
      run_cycles(400, 8,  70,  60, 4,  70);
      run_cycles(200, 20, 90,  80, 2,  90);
      do_reset();
      run_cycles(300, 6,  60,  50, 6,  60);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
